// File: rtl/hamming_decoder.sv
// -----------------------------------------------------------------------------
// hamming_decoder
// Receive-side Hamming(7,4) decoder/corrector with a two-stage valid/ready
// pipeline (full throughput, backpressure-safe).
//
// Codeword layout, positions [7:1]: parity at 1, 2, 4; data at 3, 5, 6, 7.
// The syndrome is the index of the single flipped bit (0 = clean). That bit
// is inverted before the data nibble {w7,w6,w5,w3} is extracted. A 2-bit
// error produces a nonzero syndrome and is miscorrected. It is not detected.
//
// Optional build macro: HAMMING_ERR_COUNT_EN
//   Adds parameter CNT_W, input err_clr and output err_count. err_count is a
//   saturating count of output transfers that carried err_flag=1. err_clr
//   wins over a same-cycle increment.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   in_valid     in   code_in valid
//   in_ready     out  block accepts code_in this cycle (combinational)
//   code_in      in   [7:1] received codeword
//   out_valid    out  outputs valid
//   out_ready    in   downstream accepts output
//   data_out     out  [3:0] corrected data {w7,w6,w5,w3}
//   syndrome_out out  [2:0] syndrome, index of the flipped bit or 0
//   err_flag     out  syndrome_out != 0
//   err_clr      in   clear err_count            (HAMMING_ERR_COUNT_EN only)
//   err_count    out  [CNT_W-1:0] error counter  (HAMMING_ERR_COUNT_EN only)
// -----------------------------------------------------------------------------
module hamming_decoder
`ifdef HAMMING_ERR_COUNT_EN
#(
    parameter int CNT_W = 8
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:1] code_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] data_out,
    output logic [2:0] syndrome_out,
    output logic       err_flag
`ifdef HAMMING_ERR_COUNT_EN
    ,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
`endif
);

    function automatic logic [2:0] calc_syndrome(input logic [7:1] w);
        return {w[4] ^ w[5] ^ w[6] ^ w[7],
                w[2] ^ w[3] ^ w[6] ^ w[7],
                w[1] ^ w[3] ^ w[5] ^ w[7]};
    endfunction

    function automatic logic [7:1] correct_word(input logic [7:1] w,
                                                input logic [2:0] s);
        logic [7:1] r;
        r = w;
        if (s != 3'd0) begin
            r[s] = ~r[s];
        end
        return r;
    endfunction

    function automatic logic [3:0] extract_data(input logic [7:1] c);
        return {c[7], c[6], c[5], c[3]};
    endfunction

    logic       s1_valid_q, s1_valid_d;
    logic [7:1] s1_code_q,  s1_code_d;
    logic [2:0] s1_syn_q,   s1_syn_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] data_q,      data_d;
    logic [2:0] syn_q,       syn_d;
    logic       err_q,       err_d;

    logic s1_adv;
    logic s1_load;
    logic s2_load;

    always_comb begin
        // The output register can take a new word if it is empty or draining.
        s1_adv   = ~out_valid_q | out_ready;
        in_ready = ~s1_valid_q | s1_adv;
        s1_load  = in_valid & in_ready;
        s2_load  = s1_valid_q & s1_adv;

        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        s1_syn_d    = s1_syn_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        syn_d       = syn_q;
        err_d       = err_q;

        // Stage 1: capture the word and its syndrome.
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_code_d  = code_in;
            s1_syn_d   = calc_syndrome(code_in);
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        // Stage 2: correct and register the outputs.
        if (s2_load) begin
            out_valid_d = 1'b1;
            data_d      = extract_data(correct_word(s1_code_q, s1_syn_q));
            syn_d       = s1_syn_q;
            err_d       = (s1_syn_q != 3'd0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= 4'd0;
            syn_q       <= 3'd0;
            err_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            syn_q       <= syn_d;
            err_q       <= err_d;
        end
    end

    // The stage-1 payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_code_q <= s1_code_d;
        s1_syn_q  <= s1_syn_d;
    end

    assign out_valid    = out_valid_q;
    assign data_out     = data_q;
    assign syndrome_out = syn_q;
    assign err_flag     = err_q;

`ifdef HAMMING_ERR_COUNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    logic [CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (out_valid_q & out_ready & err_q) begin
            err_count_d = sat_inc(err_count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming_decoder
// Self-checking bench for hamming_decoder. A behavioural model holds the words
// in flight in a queue. It decodes each word as "syndrome = XOR of the indices
// of the set bits". A negedge process compares every DUT output against it.
// Directed literal cases pin the model. Randomized traffic follows them.
// -----------------------------------------------------------------------------
module tb_hamming_decoder;

    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:1] code_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] data_out;
    logic [2:0] syndrome_out;
    logic       err_flag;
`ifdef HAMMING_ERR_COUNT_EN
    logic                err_clr = 1'b0;
    logic [TB_CNT_W-1:0] err_count;
`endif

    always #5 clk = ~clk;

`ifdef HAMMING_ERR_COUNT_EN
    hamming_decoder #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .code_in(code_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .syndrome_out(syndrome_out), .err_flag(err_flag),
        .err_clr(err_clr), .err_count(err_count));
`else
    hamming_decoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .code_in(code_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .syndrome_out(syndrome_out), .err_flag(err_flag));
`endif

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoding rules.
    function automatic int ref_syn(input logic [7:1] w);
        int s = 0;
        for (int i = 1; i <= 7; i++) if (w[i]) s ^= i;
        return s;
    endfunction

    function automatic int ref_data(input logic [7:1] w);
        logic [7:1] c;
        int s;
        c = w;
        s = ref_syn(w);
        if (s != 0) c[s] = ~c[s];
        return {28'd0, c[7], c[6], c[5], c[3]};
    endfunction

    function automatic logic [7:1] encode(input logic [3:0] d);
        logic [7:1] w;
        int s;
        w = '0;
        w[3] = d[0]; w[5] = d[1]; w[6] = d[2]; w[7] = d[3];
        s = ref_syn(w);
        w[1] = s[0]; w[2] = s[1]; w[4] = s[2];
        return w;
    endfunction

    function automatic logic [7:1] gen_word();
        logic [7:1] w;
        int m, a, b;
        w = encode(4'($urandom_range(0, 15)));
        m = $urandom_range(0, 3);
        a = $urandom_range(1, 7);
        if (m == 1 || m == 2) begin
            w[a] = ~w[a];
        end else if (m == 3) begin
            b = (a % 7) + 1;
            w[a] = ~w[a];
            w[b] = ~w[b];
        end
        return w;
    endfunction

    // Behavioural model: words in flight, head_out = oldest word is at output.
    logic [7:1] mq[$];
    bit         head_out = 0;
    int         mcnt = 0;
    int         dut_xfers = 0;

    always @(posedge clk) begin
        bit rdy;
        if (out_valid && out_ready) dut_xfers++;
        if (reset) begin
            mq.delete();
            head_out = 0;
            mcnt = 0;
        end else begin
            rdy = (mq.size() < 2) || out_ready;
`ifdef HAMMING_ERR_COUNT_EN
            if (err_clr) mcnt = 0;
            else if (head_out && out_ready && ref_syn(mq[0]) != 0 && mcnt < CNT_MAX) mcnt++;
`endif
            if (head_out && out_ready) begin
                void'(mq.pop_front());
                head_out = 0;
            end
            if (!head_out && mq.size() > 0) head_out = 1;
            if (in_valid && rdy) mq.push_back(code_in);
        end
    end

    // Compare process.
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_valid", int'(out_valid), int'(head_out));
            check("in_ready", int'(in_ready), int'((mq.size() < 2) || out_ready));
            if (head_out) begin
                check("data_out", int'(data_out), ref_data(mq[0]));
                check("syndrome_out", int'(syndrome_out), ref_syn(mq[0]));
                check("err_flag", int'(err_flag), int'(ref_syn(mq[0]) != 0));
            end
`ifdef HAMMING_ERR_COUNT_EN
            check("err_count", int'(err_count), mcnt);
`endif
        end
    end

    task automatic send(input logic [7:1] w);
        bit got = 0;
        in_valid = 1'b1;
        code_in = w;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
        end
        if (!got) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        bit found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            found = out_valid;
        end
        if (!found) check("out_timeout", 0, 1);
    endtask

    task automatic expect_lit(input logic [7:1] w, input int d, input int s, input int e);
        send(w);
        wait_out();
        check("lit_data", int'(data_out), d);
        check("lit_syn", int'(syndrome_out), s);
        check("lit_err", int'(err_flag), e);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int xb;
        bit acc;
        cycles(2);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_syn", int'(syndrome_out), 0);
        check("rst_err", int'(err_flag), 0);
        check("rst_in_ready", int'(in_ready), 1);
`ifdef HAMMING_ERR_COUNT_EN
        check("rst_err_count", int'(err_count), 0);
`endif
        cmp_en = 1;
        @(posedge clk); #1;

        // Directed literal cases.
        expect_lit(7'b1010101, 4'b1011, 0, 0);
        expect_lit(7'b1110101, 4'b1011, 6, 1);
`ifdef HAMMING_ERR_COUNT_EN
        @(negedge clk);
        check("cnt_after_flip", int'(err_count), 1);
`endif
        expect_lit(7'b1010100, 4'b1011, 1, 1);
        expect_lit(7'b1010110, 4'b1010, 3, 1);
        cycles(3);

        // Backpressure: four words with out_ready low for five cycles.
        xb = dut_xfers;
        out_ready = 1'b0;
        fork
            begin
                send(encode(4'd1)); send(encode(4'd2) ^ 7'b0000100);
                send(encode(4'd3)); send(encode(4'd4) ^ 7'b1000000);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", int'(in_ready), 0);
                check("bp_out_valid_held", int'(out_valid), 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        cycles(6);
        check("bp_transfers", dut_xfers - xb, 4);

        // Reset with two words in flight.
        out_ready = 1'b0;
        send(encode(4'd9));
        send(encode(4'd10));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        xb = dut_xfers;
        @(posedge clk); #1;
        out_ready = 1'b1;
        cycles(5);
        check("midrst_no_emit", dut_xfers - xb, 0);

`ifdef HAMMING_ERR_COUNT_EN
        // Saturation and clear.
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) send(encode(4'(i)) ^ 7'b0010000);
        cycles(4);
        @(negedge clk);
        check("cnt_saturated", int'(err_count), CNT_MAX);
        send(encode(4'd7) ^ 7'b0000001);
        wait_out();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("cnt_cleared", int'(err_count), 0);
        @(posedge clk); #1;
`endif

        // Randomized traffic with random backpressure; the source holds
        // a word until it is accepted.
        acc = 0;
        for (int i = 0; i < 800; i++) begin
            if (!in_valid || acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    code_in = gen_word();
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef HAMMING_ERR_COUNT_EN
            err_clr = ($urandom_range(0, 15) == 0);
`endif
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
`ifdef HAMMING_ERR_COUNT_EN
        err_clr = 1'b0;
`endif
        cycles(5);
        @(negedge clk);
        check("drained", int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
